// File: rtl/switch_router_pkg.sv
// rtl/switch_router_pkg.sv - shared widths, port select and transaction types for switch_router
package switch_router_pkg;

   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_DATA_WIDTH = 16;
   localparam logic [DEF_ADDR_WIDTH-1:0] DEF_SPLIT_ADDR = 8'h40;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_sel_e;

   typedef struct packed {
      logic [DEF_ADDR_WIDTH-1:0] addr;
      logic [DEF_DATA_WIDTH-1:0] data;
   } txn_t;

endpackage

// File: rtl/switch_port_reg.sv
// rtl/switch_port_reg.sv - one output port: transaction register, valid pulse, saturating count
module switch_port_reg
   import switch_router_pkg::*;
#(
   parameter int  CNT_WIDTH = 16,
   parameter type txn_type  = txn_t
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 load,
   input  txn_type              txn,
   output txn_type              q,
   output logic                 vld,
   output logic [CNT_WIDTH-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (rstn) begin
         q   <= '0;
         vld <= 1'b0;
         cnt <= '0;
      end else begin
         vld <= load;
         if (load) begin
            q <= txn;
            // hold at all-ones rather than wrapping
            if (cnt != '1) begin
               cnt <= cnt + CNT_WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: rtl/switch_router.sv
// rtl/switch_router.sv - address-decoding one-in/two-out registered switch
module switch_router
   import switch_router_pkg::*;
#(
   parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] SPLIT_ADDR = ADDR_WIDTH'(DEF_SPLIT_ADDR),
   parameter int                    CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  vld,
   output logic [ADDR_WIDTH-1:0] addr_a,
   output logic [DATA_WIDTH-1:0] data_a,
   output logic                  vld_a,
   output logic [ADDR_WIDTH-1:0] addr_b,
   output logic [DATA_WIDTH-1:0] data_b,
   output logic                  vld_b,
   output logic [CNT_WIDTH-1:0]  cnt_a,
   output logic [CNT_WIDTH-1:0]  cnt_b
);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } txn_w_t;

   port_sel_e sel;
   logic      load_a;
   logic      load_b;
   txn_w_t    txn_in;
   txn_w_t    q_a;
   txn_w_t    q_b;

   // loads are gated by vld so an undefined addr while idle cannot reach either port
   always_comb begin
      sel    = (addr < SPLIT_ADDR) ? PORT_A : PORT_B;
      load_a = vld && (sel == PORT_A);
      load_b = vld && (sel == PORT_B);
      txn_in = '{addr: addr, data: data};
   end

   switch_port_reg #(.CNT_WIDTH(CNT_WIDTH), .txn_type(txn_w_t)) u_port_a (
      .clk  (clk),
      .rstn (rstn),
      .load (load_a),
      .txn  (txn_in),
      .q    (q_a),
      .vld  (vld_a),
      .cnt  (cnt_a)
   );

   switch_port_reg #(.CNT_WIDTH(CNT_WIDTH), .txn_type(txn_w_t)) u_port_b (
      .clk  (clk),
      .rstn (rstn),
      .load (load_b),
      .txn  (txn_in),
      .q    (q_b),
      .vld  (vld_b),
      .cnt  (cnt_b)
   );

   assign addr_a = q_a.addr;
   assign data_a = q_a.data;
   assign addr_b = q_b.addr;
   assign data_b = q_b.data;

endmodule

// File: tb/tb_switch_router.sv
// tb/tb_switch_router.sv - table-driven self-checking bench for switch_router
module tb_switch_router;

   logic        clk = 1'b0;
   logic        rstn;
   logic [7:0]  addr;
   logic [15:0] data;
   logic        vld;

   logic [7:0]  addr_a, addr_b, addr_a4, addr_b4;
   logic [15:0] data_a, data_b, data_a4, data_b4;
   logic        vld_a, vld_b, vld_a4, vld_b4;
   logic [15:0] cnt_a, cnt_b;
   logic [3:0]  cnt_a4, cnt_b4;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   switch_router dut (
      .clk(clk), .rstn(rstn), .addr(addr), .data(data), .vld(vld),
      .addr_a(addr_a), .data_a(data_a), .vld_a(vld_a),
      .addr_b(addr_b), .data_b(data_b), .vld_b(vld_b),
      .cnt_a(cnt_a), .cnt_b(cnt_b)
   );

   switch_router #(.CNT_WIDTH(4)) dut4 (
      .clk(clk), .rstn(rstn), .addr(addr), .data(data), .vld(vld),
      .addr_a(addr_a4), .data_a(data_a4), .vld_a(vld_a4),
      .addr_b(addr_b4), .data_b(data_b4), .vld_b(vld_b4),
      .cnt_a(cnt_a4), .cnt_b(cnt_b4)
   );

   typedef struct {
      logic        rst;
      logic        v;
      logic [7:0]  a;
      logic [15:0] d;
      logic [7:0]  ea_a;
      logic [15:0] ed_a;
      logic        ev_a;
      logic [7:0]  ea_b;
      logic [15:0] ed_b;
      logic        ev_b;
      logic [15:0] ec_a;
      logic [15:0] ec_b;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(logic rst, logic v, logic [7:0] a, logic [15:0] d,
                               logic [7:0] ea_a, logic [15:0] ed_a, logic ev_a,
                               logic [7:0] ea_b, logic [15:0] ed_b, logic ev_b,
                               logic [15:0] ec_a, logic [15:0] ec_b);
      vec_t r;
      r.rst = rst; r.v = v; r.a = a; r.d = d;
      r.ea_a = ea_a; r.ed_a = ed_a; r.ev_a = ev_a;
      r.ea_b = ea_b; r.ed_b = ed_b; r.ev_b = ev_b;
      r.ec_a = ec_a; r.ec_b = ec_b;
      return r;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step=%0d actual=%h required=%h", name, idx, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic v, input logic [7:0] a, input logic [15:0] d);
      rstn = r; vld = v; addr = a; data = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rstn = 1'b1; vld = 1'b0; addr = '0; data = '0;

      //     rst  v    addr   data      addr_a data_a   va    addr_b data_b   vb    cnt_a cnt_b
      vt.push_back(mk(1, 1, 8'h10, 16'h5555, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 0, 0, 0));
      vt.push_back(mk(1, 1, 8'h10, 16'h5555, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 0, 0, 0));
      vt.push_back(mk(0, 1, 8'h3F, 16'hBEEF, 8'h3F, 16'hBEEF, 1, 8'h00, 16'h0000, 0, 1, 0));
      vt.push_back(mk(0, 1, 8'h40, 16'h1234, 8'h3F, 16'hBEEF, 0, 8'h40, 16'h1234, 1, 1, 1));
      vt.push_back(mk(0, 0, 8'hxx, 16'hxxxx, 8'h3F, 16'hBEEF, 0, 8'h40, 16'h1234, 0, 1, 1));
      vt.push_back(mk(0, 0, 8'h05, 16'hA5A5, 8'h3F, 16'hBEEF, 0, 8'h40, 16'h1234, 0, 1, 1));
      vt.push_back(mk(0, 0, 8'hC3, 16'h0F0F, 8'h3F, 16'hBEEF, 0, 8'h40, 16'h1234, 0, 1, 1));
      vt.push_back(mk(0, 0, 8'hxx, 16'h1111, 8'h3F, 16'hBEEF, 0, 8'h40, 16'h1234, 0, 1, 1));
      vt.push_back(mk(0, 0, 8'h40, 16'hxxxx, 8'h3F, 16'hBEEF, 0, 8'h40, 16'h1234, 0, 1, 1));
      vt.push_back(mk(0, 1, 8'h00, 16'h0001, 8'h00, 16'h0001, 1, 8'h40, 16'h1234, 0, 2, 1));
      vt.push_back(mk(0, 1, 8'hFF, 16'h0002, 8'h00, 16'h0001, 0, 8'hFF, 16'h0002, 1, 2, 2));
      vt.push_back(mk(0, 1, 8'h20, 16'h0003, 8'h20, 16'h0003, 1, 8'hFF, 16'h0002, 0, 3, 2));
      vt.push_back(mk(0, 1, 8'h80, 16'h0004, 8'h20, 16'h0003, 0, 8'h80, 16'h0004, 1, 3, 3));
      vt.push_back(mk(0, 1, 8'h10, 16'hAAAA, 8'h10, 16'hAAAA, 1, 8'h80, 16'h0004, 0, 4, 3));
      vt.push_back(mk(0, 1, 8'h11, 16'hBBBB, 8'h11, 16'hBBBB, 1, 8'h80, 16'h0004, 0, 5, 3));
      vt.push_back(mk(1, 1, 8'h50, 16'h9999, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 0, 0, 0));
      vt.push_back(mk(0, 1, 8'h50, 16'hCCCC, 8'h00, 16'h0000, 0, 8'h50, 16'hCCCC, 1, 0, 1));
      vt.push_back(mk(0, 1, 8'h3F, 16'hDDDD, 8'h3F, 16'hDDDD, 1, 8'h50, 16'hCCCC, 0, 1, 1));
      vt.push_back(mk(0, 0, 8'h00, 16'h0000, 8'h3F, 16'hDDDD, 0, 8'h50, 16'hCCCC, 0, 1, 1));

      @(posedge clk);
      #1;
      foreach (vt[i]) begin
         step(vt[i].rst, vt[i].v, vt[i].a, vt[i].d);
         chk("addr_a", i, 32'(addr_a), 32'(vt[i].ea_a));
         chk("data_a", i, 32'(data_a), 32'(vt[i].ed_a));
         chk("vld_a",  i, 32'(vld_a),  32'(vt[i].ev_a));
         chk("addr_b", i, 32'(addr_b), 32'(vt[i].ea_b));
         chk("data_b", i, 32'(data_b), 32'(vt[i].ed_b));
         chk("vld_b",  i, 32'(vld_b),  32'(vt[i].ev_b));
         chk("cnt_a",  i, 32'(cnt_a),  32'(vt[i].ec_a));
         chk("cnt_b",  i, 32'(cnt_b),  32'(vt[i].ec_b));
      end

      // saturation: 20 port-A transactions from reset, 4-bit counter must stick at F
      step(1, 0, 8'h00, 16'h0000);
      chk("sat_reset_cnt_a4", 0, 32'(cnt_a4), 32'h0);
      for (int n = 1; n <= 20; n++) begin
         step(0, 1, 8'(n), 16'(n * 3));
         chk("sat_cnt_a4",  n, 32'(cnt_a4), (n > 15) ? 32'hF : 32'(n));
         chk("sat_cnt_a16", n, 32'(cnt_a),  32'(n));
         chk("sat_vld_a4",  n, 32'(vld_a4), 32'h1);
      end
      chk("sat_final_cnt_a4", 20, 32'(cnt_a4), 32'hF);
      chk("sat_cnt_b4",       20, 32'(cnt_b4), 32'h0);
      chk("sat_addr_a4",      20, 32'(addr_a4), 32'h14);
      step(0, 1, 8'hF0, 16'h7777);
      chk("sat_b_after_cnt_b4", 21, 32'(cnt_b4), 32'h1);
      chk("sat_b_after_cnt_a4", 21, 32'(cnt_a4), 32'hF);
      chk("sat_b_after_data_b4", 21, 32'(data_b4), 32'h7777);
      chk("sat_b_after_vld_b4", 21, 32'(vld_b4), 32'h1);
      chk("sat_b_after_vld_a4", 21, 32'(vld_a4), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
